// File: rtl/i2c_arb_pkg.sv
// Shared constants for the two-port I2C request arbiter: port count,
// FSM state encoding and the phase-timer sizing helper.
package i2c_arb_pkg;

    localparam int NUM_REQ                = 2;
    localparam int DEFAULT_TIMEOUT_CYCLES = 1023;

    // FSM encoding kept as plain vectors so older tools and waveforms decode it.
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ISSUE   = 3'd1;
    localparam logic [2:0] ST_BUSY    = 3'd2;
    localparam logic [2:0] ST_DONE    = 3'd3;
    localparam logic [2:0] ST_RECOVER = 3'd4;

    // The phase timer counts 0 .. cycles-1, so ceil(log2(cycles)) bits suffice.
    function automatic int timer_width(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

    localparam int DEFAULT_TIMER_W = timer_width(DEFAULT_TIMEOUT_CYCLES);

endpackage

// File: rtl/i2c_req_arbiter_if.sv
// Requester and controller signals of the I2C request arbiter.
// slave  : the arbiter's view (takes requests, drives the controller).
// master : the environment's view (requesters plus the byte controller).
interface i2c_req_arbiter_if;
    import i2c_arb_pkg::*;

    // Requester side
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0][6:0] req_addr;
    logic [NUM_REQ-1:0]      req_rw;
    logic [NUM_REQ-1:0][7:0] req_wdata;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ-1:0]      rsp_valid;
    logic [7:0]              rsp_rdata;
    logic                    rsp_err;

    // Controller side
    logic [6:0]              ctl_addr;
    logic                    ctl_rw;
    logic [7:0]              ctl_data_in;
    logic                    ctl_enable;
    logic [7:0]              ctl_data_out;
    logic                    ctl_ready;

    modport slave (
        input  req_valid, req_addr, req_rw, req_wdata, ctl_data_out, ctl_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               ctl_addr, ctl_rw, ctl_data_in, ctl_enable
    );

    modport master (
        output req_valid, req_addr, req_rw, req_wdata, ctl_data_out, ctl_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               ctl_addr, ctl_rw, ctl_data_in, ctl_enable
    );

endinterface

// File: rtl/i2c_rr_arbiter.sv
// Two-way round-robin grant. The grant is combinational; the priority
// pointer moves to the other requester only when a grant is accepted.
module i2c_rr_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    // 0 = requester 0 preferred on a tie, 1 = requester 1 preferred.
    logic prio;

    // Pick the preferred requester on a tie, otherwise whichever one is asking.
    always_comb begin
        // NOTE: default assignment first so no path leaves grant unassigned (no latch).
        grant = 2'b00;
        if (req[0] && (!req[1] || !prio)) begin
            grant = 2'b01;
        end else if (req[1]) begin
            grant = 2'b10;
        end
    end

    // After an accepted grant, prefer the requester that was not served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= 1'b0;
        end else if (accept && (grant != 2'b00)) begin
            // NOTE: sequential state uses non-blocking assignments only.
            prio <= grant[0];
        end
    end

endmodule

// File: rtl/i2c_req_arbiter.sv
// i2c_req_arbiter: shares one I2C byte controller between two requesters.
// Each accepted request runs one complete controller transaction (ISSUE,
// BUSY) and is answered with a single rsp_valid pulse; a phase that
// exceeds TIMEOUT_CYCLES is aborted and answered with rsp_err.
module i2c_req_arbiter #(
    parameter int TIMEOUT_CYCLES = i2c_arb_pkg::DEFAULT_TIMEOUT_CYCLES,
    parameter int NUM_REQ        = i2c_arb_pkg::NUM_REQ
) (
    input logic              clk,
    input logic              rst_n,
    i2c_req_arbiter_if.slave bus
);
    import i2c_arb_pkg::*;

    localparam int                 TIMER_W    = timer_width(TIMEOUT_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]         state;
    logic [TIMER_W-1:0] timer;
    logic [NUM_REQ-1:0] owner_oh;
    logic [NUM_REQ-1:0] grant;
    logic               accept;
    logic               timer_hit;

    // A grant is only taken in IDLE with the controller idle; gating with
    // rst_n keeps req_ready low for the whole time reset is asserted.
    assign accept    = rst_n && (state == ST_IDLE) && bus.ctl_ready && (bus.req_valid != '0);
    assign timer_hit = (timer == TIMER_LAST);

    // The accept pulse goes straight back to the granted requester.
    assign bus.req_ready = accept ? grant : '0;

    i2c_rr_arbiter u_rr (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (bus.req_valid),
        .accept (accept),
        .grant  (grant)
    );

    // Transaction FSM: latches the granted request, drives the controller,
    // runs the per-phase timer and emits the one-cycle response pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: every register here is control or datapath state, so all of
            // it is reset; an aborted request is simply forgotten.
            state           <= ST_IDLE;
            timer           <= '0;
            owner_oh        <= '0;
            bus.rsp_valid   <= '0;
            bus.rsp_rdata   <= 8'h00;
            bus.rsp_err     <= 1'b0;
            bus.ctl_addr    <= 7'h00;
            bus.ctl_rw      <= 1'b0;
            bus.ctl_data_in <= 8'h00;
            bus.ctl_enable  <= 1'b0;
        end else begin
            // Response outputs are pulses: idle at zero unless set below.
            bus.rsp_valid <= '0;
            bus.rsp_rdata <= 8'h00;
            bus.rsp_err   <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        owner_oh        <= grant;
                        bus.ctl_addr    <= bus.req_addr[grant[1]];
                        bus.ctl_rw      <= bus.req_rw[grant[1]];
                        bus.ctl_data_in <= bus.req_wdata[grant[1]];
                        bus.ctl_enable  <= 1'b1;
                        timer           <= '0;
                        state           <= ST_ISSUE;
                    end
                end

                // Hold enable until the controller shows it has started.
                ST_ISSUE: begin
                    if (!bus.ctl_ready) begin
                        bus.ctl_enable <= 1'b0;
                        timer          <= '0;
                        state          <= ST_BUSY;
                    end else if (timer_hit) begin
                        bus.ctl_enable <= 1'b0;
                        bus.rsp_valid  <= owner_oh;
                        bus.rsp_err    <= 1'b1;
                        state          <= ST_RECOVER;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                // Enable is already low, so the controller ends with STOP.
                ST_BUSY: begin
                    if (bus.ctl_ready) begin
                        bus.rsp_valid <= owner_oh;
                        bus.rsp_rdata <= bus.ctl_rw ? bus.ctl_data_out : 8'h00;
                        state         <= ST_DONE;
                    end else if (timer_hit) begin
                        bus.rsp_valid <= owner_oh;
                        bus.rsp_err   <= 1'b1;
                        state         <= ST_RECOVER;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                // The response pulse is visible during this cycle.
                ST_DONE: begin
                    state <= ST_IDLE;
                end

                // Error already reported; wait for the controller to go idle.
                ST_RECOVER: begin
                    if (bus.ctl_ready) begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/i2c_req_arbiter.md
I2C_REQ_ARBITER -- requirements
Module: i2c_req_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1023: clk cycles allowed per controller phase (ISSUE or BUSY) before abort.
REQ-002 Parameter NUM_REQ, default 2, fixed at 2: number of requester ports.
REQ-003 clk  input  1  single clock for all logic; one clock, reset is asynchronous and active-low.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  2  per-requester transaction request; held high until req_ready.
REQ-006 req_addr  input  2x7  per-requester 7-bit I2C slave address.
REQ-007 req_rw  input  2  per-requester direction: 0 = write, 1 = read.
REQ-008 req_wdata  input  2x8  per-requester write byte.
REQ-009 req_ready  output  2  one-cycle accept pulse to the granted requester.
REQ-010 rsp_valid  output  2  one-cycle completion pulse to the owning requester.
REQ-011 rsp_rdata  output  8  read byte, valid with rsp_valid; 0 for writes and errors.
REQ-012 rsp_err  output  1  timeout flag, valid with rsp_valid.
REQ-013 ctl_addr  output  7  to controller addr.
REQ-014 ctl_rw  output  1  to controller rw.
REQ-015 ctl_data_in  output  8  to controller data_in.
REQ-016 ctl_enable  output  1  to controller enable.
REQ-017 ctl_data_out  input  8  from controller data_out.
REQ-018 ctl_ready  input  1  from controller ready; high = controller idle.

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE, BUSY, DONE, RECOVER.
REQ-020 IDLE: when any req_valid is high and ctl_ready = 1, grant one requester, pulse its req_ready for that cycle, latch addr/rw/wdata/owner, and go to ISSUE next cycle.
REQ-021 Arbitration SHALL be round-robin: with both requesting, grant the requester not granted last; after reset, requester 0 has priority.
REQ-022 A single requester SHALL be granted regardless of round-robin history.
REQ-023 ISSUE: hold ctl_enable = 1 with latched fields until ctl_ready = 0, then go to BUSY.
REQ-024 BUSY: ctl_enable = 0; on ctl_ready = 1, capture ctl_data_out (reads) or 0 (writes) and go to DONE.
REQ-025 ctl_enable SHALL be low outside ISSUE, so the controller always finishes with STOP and never chains transactions.
REQ-026 DONE: pulse rsp_valid[owner] for one cycle with rsp_rdata and rsp_err = 0, then return to IDLE.
REQ-027 A phase timer SHALL clear on entry to ISSUE and to BUSY; reaching TIMEOUT_CYCLES SHALL drive ctl_enable low and go to RECOVER.
REQ-028 RECOVER: pulse rsp_valid[owner] with rsp_err = 1 and rsp_rdata = 0, then wait in RECOVER until ctl_ready = 1, then go to IDLE.
REQ-029 req_valid deasserted before grant SHALL be ignored without side effects.
REQ-030 ctl_* outputs SHALL be registered, and ctl fields SHALL stay stable from ISSUE entry to DONE or RECOVER.
REQ-031 The minimum request-to-response latency SHALL be grant cycle + 1 + controller busy time + 1 (DONE).

Reset
REQ-032 Asserting rst_n low SHALL, asynchronously and at any state, force: state = IDLE; req_ready = 0; rsp_valid = 0; rsp_rdata = 0; rsp_err = 0; ctl_enable = 0; ctl_addr = 0; ctl_rw = 0; ctl_data_in = 0; timer = 0; round-robin pointer giving requester 0 priority.
REQ-033 Reset in mid-transaction SHALL produce no response pulse, and the aborted request SHALL be lost.

Structure
REQ-034 Package i2c_arb_pkg SHALL hold the FSM state encoding, NUM_REQ, and the timer width derived from TIMEOUT_CYCLES.
REQ-035 A sub-module i2c_rr_arbiter SHALL implement 2-way round-robin grant with a pointer update on accept.

Verification
REQ-036 Req0 write addr 0x50, data 0xA5 with a model controller -> one req_ready[0] pulse; ctl_enable high until ready falls; rsp_valid[0] with err = 0 and rdata = 0x00.
REQ-037 Req1 read addr 0x68, slave returns 0x3C -> rsp_valid[1] with rsp_rdata = 0x3C and err = 0.
REQ-038 Both requesters valid continuously for 4 transactions -> grant order 0, 1, 0, 1.
REQ-039 Controller held ready = 1 after enable, TIMEOUT_CYCLES = 15 -> rsp_err = 1 pulse 15 cycles after ISSUE entry; FSM stays in RECOVER until ready.
REQ-040 rst_n pulsed low during BUSY -> all outputs return to reset values immediately; no rsp_valid; next request is granted normally.
